// File: rtl/adc_pkg.sv
// Shared ADC definitions used by the pulse generator and the shaping filter:
// sample width, pulse-generator state type and a code-saturation helper.
package adc_pkg;

   localparam int unsigned SIZE_ADC_DATA = 12;
   localparam int unsigned AdcMax        = (1 << SIZE_ADC_DATA) - 1;
   localparam logic [15:0] LfsrSeed      = 16'hACE1;

   typedef enum logic [1:0] {
      StIdle,
      StRise,
      StDecay
   } pulse_state_e;

   // Clamp a signed intermediate into the legal ADC code range.
   function automatic logic [SIZE_ADC_DATA-1:0] adc_sat(input int value);
      if (value < 0) begin
         return '0;
      end
      if (value > int'(AdcMax)) begin
         return '1;
      end
      return SIZE_ADC_DATA'(value);
   endfunction

endpackage

// File: rtl/pulse_gen_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advancing every cycle; supplies
// the low bits used as dither on the synthetic ADC stream.
module pulse_gen_lfsr
   import adc_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   output logic [2:0] noise_sel_o
);

   logic [15:0] lfsr_q, lfsr_d;
   logic        feedback;

   always_comb begin
      feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      lfsr_d   = {feedback, lfsr_q[15:1]};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lfsr_q <= LfsrSeed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign noise_sel_o = lfsr_q[2:0];

endmodule

// File: rtl/adc_pulse_gen.sv
// Synthetic detector-pulse source: linear rise to a target, exponential decay back to zero,
// with pileup restarts. Define ADC_PULSE_NOISE_EN to add LFSR dither (-4..+3) to adc_data_o.
module adc_pulse_gen
   import adc_pkg::*;
#(
   parameter int unsigned BASELINE    = 100,
   parameter int unsigned RISE_SHIFT  = 2,
   parameter int unsigned DECAY_SHIFT = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic [SIZE_ADC_DATA-1:0] amplitude_i,
   output logic                     ready_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [SIZE_ADC_DATA-1:0] adc_data_o
);

   localparam int unsigned W    = SIZE_ADC_DATA;
   localparam int unsigned CntW = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
   localparam logic [CntW-1:0] LastStep = CntW'((1 << RISE_SHIFT) - 1);

   pulse_state_e  state_q, state_d;
   logic [W-1:0]  y_q, y_d;
   logic [W-1:0]  target_q, target_d;
   logic [W-1:0]  step_q, step_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [W-1:0]  adc_q, adc_d;

   logic          accept;
   logic          tail;
   logic [W-1:0]  y_base;
   logic [W:0]    sum_new;
   logic [W-1:0]  target_new;
   logic [W-1:0]  step_new;
   int            noise;

`ifdef ADC_PULSE_NOISE_EN
   logic [2:0] noise_sel;

   pulse_gen_lfsr u_lfsr (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .noise_sel_o (noise_sel)
   );

   assign noise = int'({1'b0, noise_sel}) - 4;
`else
   assign noise = 0;
`endif

   // A start coinciding with the end of the tail sees y as already zero.
   always_comb begin
      tail       = (y_q >> DECAY_SHIFT) == '0;
      accept     = start_i && (state_q != StRise);
      y_base     = ((state_q == StDecay) && tail) ? '0 : y_q;
      sum_new    = {1'b0, y_base} + {1'b0, amplitude_i};
      target_new = sum_new[W] ? '1 : sum_new[W-1:0];
      step_new   = (target_new - y_base) >> RISE_SHIFT;
   end

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      target_d = target_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d  = StRise;
               y_d      = y_base;
               target_d = target_new;
               step_d   = step_new;
               cnt_d    = '0;
            end
         end
         StRise: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastStep) begin
               y_d     = target_q;
               state_d = StDecay;
            end else begin
               y_d = y_q + step_q;
            end
         end
         StDecay: begin
            if (accept) begin
               state_d  = StRise;
               y_d      = y_base;
               target_d = target_new;
               step_d   = step_new;
               cnt_d    = '0;
            end else if (tail) begin
               state_d = StIdle;
               y_d     = '0;
               done_d  = 1'b1;
            end else begin
               y_d = y_q - (y_q >> DECAY_SHIFT);
            end
         end
         default: begin
            state_d = StIdle;
            y_d     = '0;
         end
      endcase

      adc_d = adc_sat(int'(BASELINE) + int'(y_d) + noise);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         y_q      <= '0;
         target_q <= '0;
         step_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         adc_q    <= adc_sat(int'(BASELINE));
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         target_q <= target_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         adc_q    <= adc_d;
      end
   end

   assign ready_o    = (state_q != StRise);
   assign busy_o     = (state_q != StIdle);
   assign done_o     = done_q;
   assign adc_data_o = adc_q;

endmodule

// File: tb/tb_adc_pulse_gen.sv
// Self-checking bench for adc_pulse_gen: directed pulse scenarios plus a randomized run
// compared against a trajectory-based reference model.
module tb_adc_pulse_gen;
   import adc_pkg::*;

   localparam int W    = SIZE_ADC_DATA;
   localparam int MAXV = (1 << W) - 1;
   localparam int BASE = 100;
   localparam int RS   = 2;
   localparam int DS   = 4;
   localparam int NR   = 1 << RS;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] amplitude;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] adc_data;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: each accepted start precomputes the full future y trajectory.
   int m_y;
   int m_rise_left;
   bit m_done;
   int traj_q[$];
   bit tdone_q[$];

   always #5 clk = ~clk;

   adc_pulse_gen #(
      .BASELINE    (BASE),
      .RISE_SHIFT  (RS),
      .DECAY_SHIFT (DS)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .amplitude_i (amplitude),
      .ready_o     (ready),
      .busy_o      (busy),
      .done_o      (done),
      .adc_data_o  (adc_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_edge(input bit rst, input bit st, input int amp);
      int base, tgt, stp, v;
      if (rst) begin
         traj_q.delete();
         tdone_q.delete();
         m_y = 0;
         m_rise_left = 0;
         m_done = 0;
         return;
      end
      m_done = 0;
      if (st && m_rise_left == 0) begin
         base = ((m_y >> DS) == 0) ? 0 : m_y;
         tgt  = (base + amp > MAXV) ? MAXV : base + amp;
         stp  = (tgt - base) >> RS;
         traj_q.delete();
         tdone_q.delete();
         for (int k = 1; k < NR; k++) begin
            traj_q.push_back(base + k * stp);
            tdone_q.push_back(1'b0);
         end
         traj_q.push_back(tgt);
         tdone_q.push_back(1'b0);
         v = tgt;
         while ((v >> DS) != 0) begin
            v = v - (v >> DS);
            traj_q.push_back(v);
            tdone_q.push_back(1'b0);
         end
         traj_q.push_back(0);
         tdone_q.push_back(1'b1);
         m_y = base;
         m_rise_left = NR;
      end else if (traj_q.size() > 0) begin
         m_y = traj_q.pop_front();
         m_done = tdone_q.pop_front();
         if (m_rise_left > 0) m_rise_left--;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500 && busy; i++) tick();
      tests_run++;
      if (busy !== 1'b0) begin
         $display("FAIL wait_idle: busy=%b, expected 0 within 500 cycles", busy);
         tests_failed++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      amplitude = '0;
      tick();
      tick();
      tests_run++;
      if (adc_data !== 12'd100 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
         $display("FAIL reset: adc=%0d busy=%b ready=%b done=%b, expected 100 0 1 0",
                  adc_data, busy, ready, done);
         tests_failed++;
      end
      reset = 1'b0;
      tick();
      tests_run++;
      if (adc_data !== 12'd100 || busy !== 1'b0) begin
         $display("FAIL reset_idle: adc=%0d busy=%b, expected 100 0", adc_data, busy);
         tests_failed++;
      end
   endtask

   // Leaves the pulse at N+6 (y=880) for test_pileup.
   task automatic test_basic_pulse();
      logic [W-1:0] exp_adc [6] = '{12'd350, 12'd600, 12'd850, 12'd1100, 12'd1038, 12'd980};
      start = 1'b1;
      amplitude = 12'd1000;
      tick();
      start = 1'b0;
      amplitude = '0;
      tests_run++;
      if (adc_data !== 12'd100 || busy !== 1'b1 || ready !== 1'b0) begin
         $display("FAIL basic_accept: adc=%0d busy=%b ready=%b, expected 100 1 0",
                  adc_data, busy, ready);
         tests_failed++;
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         tests_run++;
         if (adc_data !== exp_adc[i]) begin
            $display("FAIL basic_adc[N+%0d]: got %0d, expected %0d", i + 1, adc_data, exp_adc[i]);
            tests_failed++;
         end
         tests_run++;
         if (ready !== (i >= 3)) begin
            $display("FAIL basic_ready[N+%0d]: got %b, expected %b", i + 1, ready, i >= 3);
            tests_failed++;
         end
      end
   endtask

   task automatic test_pileup();
      logic [W-1:0] exp_adc [4] = '{12'd1105, 12'd1230, 12'd1355, 12'd1480};
      start = 1'b1;
      amplitude = 12'd500;
      tick();
      start = 1'b0;
      amplitude = '0;
      tests_run++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL pileup_accept: ready=%b busy=%b, expected 0 1", ready, busy);
         tests_failed++;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (adc_data !== exp_adc[i]) begin
            $display("FAIL pileup_adc[%0d]: got %0d, expected %0d", i + 1, adc_data, exp_adc[i]);
            tests_failed++;
         end
      end
   endtask

   task automatic test_tail();
      logic [W-1:0] prev_adc;
      logic         prev_busy;
      int           n;
      prev_adc = adc_data;
      prev_busy = busy;
      n = 0;
      while (!done && n < 500) begin
         prev_adc = adc_data;
         prev_busy = busy;
         tick();
         n++;
      end
      tests_run++;
      if (done !== 1'b1) begin
         $display("FAIL tail_done: done never seen within 500 cycles");
         tests_failed++;
      end
      tests_run++;
      if (adc_data !== 12'd100 || busy !== 1'b0 || ready !== 1'b1) begin
         $display("FAIL tail_state: adc=%0d busy=%b ready=%b, expected 100 0 1",
                  adc_data, busy, ready);
         tests_failed++;
      end
      tests_run++;
      if (prev_busy !== 1'b1 || prev_adc > 12'd115) begin
         $display("FAIL tail_prev: adc=%0d busy=%b, expected <=115 and 1", prev_adc, prev_busy);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (done !== 1'b0) begin
         $display("FAIL tail_strobe: done=%b one cycle later, expected 0", done);
         tests_failed++;
      end
   endtask

   task automatic test_saturation();
      start = 1'b1;
      amplitude = 12'd4095;
      tick();
      start = 1'b0;
      amplitude = '0;
      tick();
      tests_run++;
      if (adc_data !== 12'd1123) begin
         $display("FAIL sat_first: got %0d, expected 1123", adc_data);
         tests_failed++;
      end
      tick();
      tick();
      tick();
      tests_run++;
      if (adc_data !== 12'd4095) begin
         $display("FAIL sat_peak: got %0d, expected 4095", adc_data);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (adc_data !== 12'd3940) begin
         $display("FAIL sat_decay: got %0d, expected 3940", adc_data);
         tests_failed++;
      end
      wait_idle();
   endtask

   task automatic test_ignored_start();
      logic [W-1:0] exp_adc [6] = '{12'd350, 12'd600, 12'd850, 12'd1100, 12'd1038, 12'd980};
      start = 1'b1;
      amplitude = 12'd1000;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         start = (i == 1);
         amplitude = (i == 1) ? 12'd2000 : 12'd0;
         tick();
         tests_run++;
         if (adc_data !== exp_adc[i]) begin
            $display("FAIL ignored_adc[N+%0d]: got %0d, expected %0d", i + 1, adc_data, exp_adc[i]);
            tests_failed++;
         end
      end
      start = 1'b0;
      wait_idle();
   endtask

   task automatic test_zero_amp();
      start = 1'b1;
      amplitude = '0;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         tests_run++;
         if (adc_data !== 12'd100 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL zero_hold[N+%0d]: adc=%0d busy=%b done=%b, expected 100 1 0",
                     i, adc_data, busy, done);
            tests_failed++;
         end
      end
      tick();
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL zero_done: done=%b busy=%b, expected 1 0", done, busy);
         tests_failed++;
      end
      // Second zero pulse: a start on the exit cycle must win over done.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      start = 1'b1;
      amplitude = 12'd800;
      tick();
      start = 1'b0;
      amplitude = '0;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b1 || ready !== 1'b0 || adc_data !== 12'd100) begin
         $display("FAIL exit_start: done=%b busy=%b ready=%b adc=%0d, expected 0 1 0 100",
                  done, busy, ready, adc_data);
         tests_failed++;
      end
      tick();
      tests_run++;
      if (adc_data !== 12'd300) begin
         $display("FAIL exit_start_rise: got %0d, expected 300", adc_data);
         tests_failed++;
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_pulse();
      start = 1'b1;
      amplitude = 12'd1000;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if (adc_data !== 12'd100 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
         $display("FAIL midreset: adc=%0d busy=%b ready=%b done=%b, expected 100 0 1 0",
                  adc_data, busy, ready, done);
         tests_failed++;
      end
      start = 1'b1;
      amplitude = 12'd400;
      tick();
      start = 1'b0;
      tick();
      tests_run++;
      if (adc_data !== 12'd200 || busy !== 1'b1) begin
         $display("FAIL midreset_rise: adc=%0d busy=%b, expected 200 1", adc_data, busy);
         tests_failed++;
      end
      wait_idle();
   endtask

   task automatic test_random();
      int amp, exp_adc, shown;
      bit st, rs;
      shown = 0;
      reset = 1'b1;
      start = 1'b0;
      model_edge(1'b1, 1'b0, 0);
      tick();
      for (int c = 0; c < 4000; c++) begin
         rs = ($urandom_range(0, 499) == 0);
         st = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 7))
            0:       amp = 0;
            1:       amp = MAXV;
            2:       amp = $urandom_range(0, 63);
            default: amp = $urandom_range(0, MAXV);
         endcase
         reset = rs;
         start = st;
         amplitude = W'(amp);
         model_edge(rs, st, amp);
         tick();
         exp_adc = (BASE + m_y > MAXV) ? MAXV : BASE + m_y;
         tests_run++;
         if (int'(adc_data) != exp_adc || ready !== (m_rise_left == 0) ||
             busy !== (traj_q.size() > 0) || done !== m_done) begin
            tests_failed++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random[%0d]: adc=%0d ready=%b busy=%b done=%b, expected %0d %b %b %b",
                        c, adc_data, ready, busy, done, exp_adc, m_rise_left == 0,
                        traj_q.size() > 0, m_done);
            end
         end
      end
      reset = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_pulse();
      test_pileup();
      test_tail();
      test_saturation();
      test_ignored_start();
      test_zero_amp();
      test_reset_mid_pulse();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/adc_pulse_gen.md
ADC_PULSE_GEN -- requirements
Module: adc_pulse_gen

Interface
REQ-001 SHALL have parameter BASELINE, default 100: idle output level in ADC codes.
REQ-002 SHALL have parameter RISE_SHIFT, default 2: the rise lasts 2^RISE_SHIFT cycles.
REQ-003 SHALL have parameter DECAY_SHIFT, default 4: per-cycle decay is y - (y >> DECAY_SHIFT).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: pulse request, sampled every cycle.
REQ-007 SHALL have port amplitude, input, SIZE_ADC_DATA bits: unsigned pulse height, sampled with an accepted start.
REQ-008 SHALL have port ready, output, 1 bit: start is accepted this cycle (state IDLE or DECAY).
REQ-009 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle strobe when the pulse tail ends.
REQ-011 SHALL have port adc_data, output, SIZE_ADC_DATA bits: synthetic ADC sample stream that feeds the shaping filter.

Function
REQ-012 SHALL implement states IDLE, RISE and DECAY with the transitions below.
- IDLE -> RISE on start.
- RISE -> DECAY after 2^RISE_SHIFT steps.
- DECAY -> IDLE when (y >> DECAY_SHIFT) == 0.
- DECAY -> RISE on start (pileup).
REQ-013 SHALL, on an accepted start, latch base = y and target = min(y + amplitude, 2^SIZE_ADC_DATA - 1), with step = (target - base) >> RISE_SHIFT.
REQ-014 SHALL, in RISE, add step to y on each of the first 2^RISE_SHIFT - 1 steps, and load y = target exactly on the last step, then enter DECAY.
REQ-015 SHALL, in DECAY, update y <= y - (y >> DECAY_SHIFT) each cycle.
REQ-016 SHALL, in DECAY when (y >> DECAY_SHIFT) == 0, load y = 0, enter IDLE and assert done for one cycle.
REQ-017 SHALL ignore start while in RISE (ready = 0), with no latching and no side effects.
REQ-018 SHALL register adc_data on the same edge as y, as adc_data = min(BASELINE + y_next, 2^SIZE_ADC_DATA - 1), so there is zero added latency from y.
REQ-019 SHALL, with start at edge N, produce the first nonzero y at edge N+1 and reach y = target at edge N+2^RISE_SHIFT.
REQ-020 SHALL, for amplitude = 0, still traverse RISE (y constant), then DECAY, then IDLE with done.
REQ-021 SHALL let a start on the same cycle as the DECAY exit win: go to RISE with base = 0 and no done.

Reset
REQ-022 SHALL, while reset is high at a clock edge, set state = IDLE, y = 0, adc_data = BASELINE, ready = 1, busy = 0, done = 0, clear step/target/base, and seed the LFSR.
REQ-023 SHALL abandon any pulse in progress on reset mid-RISE or mid-DECAY; the first cycle after reset behaves as IDLE.

Configuration
REQ-024 SHALL, with ADC_PULSE_NOISE_EN defined, compile in a 16-bit Fibonacci LFSR.
- Polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every cycle.
- Adds signed (lfsr[2:0] - 4), range -4..+3, to adc_data, saturated to 0..2^SIZE_ADC_DATA-1.
REQ-025 SHALL, without ADC_PULSE_NOISE_EN, contain no LFSR logic, and adc_data SHALL be exactly per REQ-018.

Structure
REQ-026 SHALL take SIZE_ADC_DATA (default 12) and the state enum type from shared package adc_pkg, which the filter also uses.
REQ-027 SHALL place the LFSR in sub-module pulse_gen_lfsr, instantiated only under ADC_PULSE_NOISE_EN.

Verification
Defaults throughout (SIZE_ADC_DATA=12, BASELINE=100, RISE_SHIFT=2, DECAY_SHIFT=4), ADC_PULSE_NOISE_EN undefined.
REQ-028 SHALL cover a basic pulse: start=1, amplitude=1000 at edge N -> adc_data 350, 600, 850, 1100 at N+1..N+4, then 1038 at N+5 and 980 at N+6; ready=0 during N+1..N+3.
REQ-029 SHALL cover saturation: amplitude=4095 from IDLE -> target 4095, step 1023, adc_data 4095 at N+4 (clamped), then 3940.
REQ-030 SHALL cover tail end: DECAY with y=15 -> next edge y=0, adc_data=100, done=1 for exactly one cycle, busy=0.
REQ-031 SHALL cover pileup: start with amplitude=500 in DECAY at y=880 -> step 125; adc_data 1105, 1230, 1355, then 1480 (y=1380).
REQ-032 SHALL cover ignored start: start with amplitude=2000 at N+2 of a 1000 pulse -> trace identical to REQ-028.
REQ-033 SHALL cover reset mid-pulse: reset=1 at N+2 -> adc_data=100, busy=0, ready=1 on that edge; a start at the next edge rises from base 0.
